tile_cmd_sched: RTL and testbench

- APB3 slave command scheduler for the tile-game datapath.
- The CPU writes 32-bit row/tile command words over APB into an internal FIFO.
- A period timer releases one command per tick to the downstream tile renderer via a valid/ready handshake.
- Sits between the APB bus fabric and the tile datapath; replaces direct single-register capture with buffered, paced delivery.

---
 rtl/tile_cmd_sched.sv | 197 +++++++++++++++++++
 tb/tb_tile_cmd_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tile_cmd_sched.sv
// APB3 command scheduler: CPU pushes 32-bit tile commands into a FIFO, and a period timer releases one per tick.
// Latency: out_valid rises the cycle after a tick if the FIFO is non-empty. APB has zero wait states and prdata is combinational in the access phase.
// Backpressure: out_valid/out_data stay stable until out_ready. A CMD write to a full FIFO is dropped with pslverr.
// Ports: clk/res (async active-low), APB3 slave (psel, penable, pwrite, paddr, pwdata, prdata, pready, pslverr),
//        command stream (out_valid, out_data, out_ready) and the period pulse tick.
// Optional macro TILE_SCHED_IRQ_EN adds the irq output, CTRL[15:8] LOWMARK and CTRL[2] IRQ_MASK.
module tile_cmd_sched #(
  parameter int DEPTH    = 8,
  parameter int PERIOD_W = 24,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              res,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [31:0]       pwdata,
  output logic [31:0]       prdata,
  output logic              pready,
  output logic              pslverr,
  output logic              out_valid,
  output logic [31:0]       out_data,
  input  logic              out_ready,
  output logic              tick
`ifdef TILE_SCHED_IRQ_EN
  ,
  output logic              irq
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_ISSUE = 2'd2} state_t;

  state_t              state, state_nxt;
  logic [31:0]         mem [DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count;
  logic                en, ovf, und;
  logic [PERIOD_W-1:0] period, cnt, per_m1;
`ifdef TILE_SCHED_IRQ_EN
  logic [7:0]          lowmark;
  logic                irq_mask;
`endif

  // APB decode
  logic       access, wr_acc, rd_acc;
  logic [1:0] reg_sel;
  logic       cmd_wr, stat_wr, ctrl_wr, per_wr;
  logic       full, empty, flush, push, pop, en_nxt;

  assign access  = psel & penable;
  assign wr_acc  = access & pwrite;
  assign rd_acc  = access & ~pwrite;
  assign reg_sel = paddr[3:2];
  assign cmd_wr  = wr_acc & (reg_sel == 2'd0);
  assign stat_wr = wr_acc & (reg_sel == 2'd1);
  assign ctrl_wr = wr_acc & (reg_sel == 2'd2);
  assign per_wr  = wr_acc & (reg_sel == 2'd3);

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign flush   = ctrl_wr & pwdata[1];
  // Fullness is judged before any same-cycle pop, so a push at full is always rejected.
  assign push    = cmd_wr & ~full & ~flush;
  assign pop     = (state == S_ISSUE) & out_ready & ~flush;
  assign en_nxt  = ctrl_wr ? pwdata[0] : en;

  assign pready  = 1'b1;
  assign pslverr = cmd_wr & full;

  // Period timer: PERIOD=0 behaves as 1, i.e. expiry on every cycle.
  assign per_m1 = (period == '0) ? '0 : period - PERIOD_W'(1);
  assign tick   = en & (cnt == per_m1);

  always_ff @(posedge clk or negedge res) begin
    if (!res)                cnt <= '0;
    else if (!en || per_wr)  cnt <= '0;
    else if (tick)           cnt <= '0;
    else                     cnt <= cnt + PERIOD_W'(1);
  end

  // Control/status registers
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      en     <= 1'b0;
      period <= '0;
      ovf    <= 1'b0;
      und    <= 1'b0;
`ifdef TILE_SCHED_IRQ_EN
      lowmark  <= '0;
      irq_mask <= 1'b0;
`endif
    end else begin
      en <= en_nxt;
      if (per_wr) period <= pwdata[PERIOD_W-1:0];
`ifdef TILE_SCHED_IRQ_EN
      if (ctrl_wr) begin
        lowmark  <= pwdata[15:8];
        irq_mask <= pwdata[2];
      end
`endif
      // Setting wins over a same-cycle W1C clear.
      ovf <= (ovf & ~(stat_wr & pwdata[10])) | (cmd_wr & full);
      und <= (und & ~(stat_wr & pwdata[11])) | ((state == S_WAIT) & tick & empty);
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= pwdata;
  end

  // FSM state register
  always_ff @(posedge clk or negedge res) begin
    if (!res) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // FSM next state; ticks while in ISSUE are deliberately ignored.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (en) state_nxt = S_WAIT;
      S_WAIT:  if (!en) state_nxt = S_IDLE;
               else if (tick && !empty) state_nxt = S_ISSUE;
      S_ISSUE: if (pop) state_nxt = en ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    // Flush abandons an in-flight command without a handshake.
    if (flush) state_nxt = en_nxt ? S_WAIT : S_IDLE;
  end

  // FSM outputs
  always_comb begin
    out_valid = (state == S_ISSUE);
  end

  // Head is captured on entry to ISSUE; it cannot change until the pop, and it holds afterwards.
  always_ff @(posedge clk or negedge res) begin
    if (!res)                                          out_data <= '0;
    else if (state_nxt == S_ISSUE && state != S_ISSUE) out_data <= mem[rd_ptr];
  end

  // Read mux
  logic [31:0] status_rd, ctrl_rd, per_rd;
  always_comb begin
    status_rd        = '0;
    status_rd[7:0]   = 8'(count);
    status_rd[8]     = full;
    status_rd[9]     = empty;
    status_rd[10]    = ovf;
    status_rd[11]    = und;
    status_rd[13:12] = state;
    ctrl_rd          = '0;
    ctrl_rd[0]       = en;
`ifdef TILE_SCHED_IRQ_EN
    ctrl_rd[2]       = irq_mask;
    ctrl_rd[15:8]    = lowmark;
`endif
    per_rd                 = '0;
    per_rd[PERIOD_W-1:0]   = period;
    prdata = '0;
    if (rd_acc) begin
      case (reg_sel)
        2'd1:    prdata = status_rd;
        2'd2:    prdata = ctrl_rd;
        2'd3:    prdata = per_rd;
        default: prdata = '0;
      endcase
    end
  end

`ifdef TILE_SCHED_IRQ_EN
  assign irq = ~irq_mask & ((en & (8'(count) <= lowmark)) | ovf | und);
`endif

endmodule

// File: tb/tb_tile_cmd_sched.sv
module tb_tile_cmd_sched;

  logic        clk = 1'b0;
  logic        res;
  logic        psel, penable, pwrite;
  logic [7:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        pready, pslverr;
  logic        out_valid, out_ready, tick;
  logic [31:0] out_data;
`ifdef TILE_SCHED_IRQ_EN
  logic        irq;
`endif

  always #5 clk = ~clk;

  tile_cmd_sched dut (
    .clk(clk), .res(res),
    .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
    .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready), .tick(tick)
`ifdef TILE_SCHED_IRQ_EN
    , .irq(irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;   // read data for reads, pslverr for writes
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Caller is positioned just after a rising edge; returns just after the edge that ends the access.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     output logic [31:0] rdata, output logic err);
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    @(negedge clk);
    rdata = prdata;
    err   = pslverr;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_w(input logic [7:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        er;
    apb(1'b1, addr, wdata, rd, er);
  endtask

  task automatic rd_chk(input string name, input logic [7:0] addr, input logic [31:0] exp);
    logic [31:0] rd;
    logic        er;
    apb(1'b0, addr, 32'h0, rd, er);
    chk(name, rd, exp);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] rd, w;
    logic        er;
    logic [31:0] q[$];
    logic [31:0] expq[$];
    int          n, p, per, c, last_tick, idx;
    logic        prev_ov, prev_tick, ovf_exp;

    res = 1'b0; psel = 0; penable = 0; pwrite = 0; paddr = 0; pwdata = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_tick", {31'b0, tick}, 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", {31'b0, pslverr}, 0);
    chk("rst_pready", {31'b0, pready}, 1);
    res = 1'b1;
    step();

    // ---------------- register table (EN stays 0) ----------------
    tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0200});
    tbl.push_back('{1'b0, 8'h0C, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 8'h08, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 8'h00, 32'h0, 32'h0});
    tbl.push_back('{1'b1, 8'h0C, 32'hFF12_3456, 32'h0});
    tbl.push_back('{1'b0, 8'h0C, 32'h0, 32'h0012_3456});
    tbl.push_back('{1'b1, 8'h08, 32'hFFFF_FFFE, 32'h0});
    tbl.push_back('{1'b0, 8'h08, 32'h0, 32'h0});
    for (int i = 0; i < 8; i++) tbl.push_back('{1'b1, 8'h00, 32'h11 * (i + 1), 32'h0});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0108});
    tbl.push_back('{1'b1, 8'h00, 32'h99, 32'h1});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0508});
    tbl.push_back('{1'b1, 8'h04, 32'h400, 32'h0});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0108});
    tbl.push_back('{1'b1, 8'h00, 32'h9A, 32'h1});
    tbl.push_back('{1'b1, 8'h08, 32'h2, 32'h0});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0600});
    tbl.push_back('{1'b1, 8'hF4, 32'h0, 32'h0});
    tbl.push_back('{1'b0, 8'hF5, 32'h0, 32'h0000_0600});
    tbl.push_back('{1'b1, 8'h04, 32'hC00, 32'h0});
    tbl.push_back('{1'b0, 8'h04, 32'h0, 32'h0000_0200});
    foreach (tbl[i]) begin
      apb(tbl[i].wr, tbl[i].addr, tbl[i].wdata, rd, er);
      if (tbl[i].wr) chk($sformatf("tbl[%0d] pslverr", i), {31'b0, er}, tbl[i].exp);
      else           chk($sformatf("tbl[%0d] prdata", i), rd, tbl[i].exp);
    end

    // ---------------- paced release, PERIOD=4 ----------------
    apb_w(8'h0C, 4);
    apb_w(8'h00, 32'hA1);
    apb_w(8'h00, 32'hB2);
    out_ready = 1'b1;
    apb_w(8'h08, 1);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      chk($sformatf("p4_tick c%0d", k), {31'b0, tick}, {31'b0, (k % 4) == 3});
      chk($sformatf("p4_valid c%0d", k), {31'b0, out_valid}, {31'b0, (k == 4) || (k == 8)});
      if (k == 4)  chk("p4_data0", out_data, 32'hA1);
      if (k == 8)  chk("p4_data1", out_data, 32'hB2);
      if (k == 12) chk("p4_data_hold", out_data, 32'hB2);
      step();
    end
    rd_chk("p4_status_underrun", 8'h04, 32'h0000_1A00);
    apb_w(8'h08, 0);
    apb_w(8'h04, 32'hC00);
    out_ready = 1'b0;

    // ---------------- stall in ISSUE, then flush ----------------
    apb_w(8'h0C, 2);
    apb_w(8'h00, 32'hC3);
    apb_w(8'h00, 32'hD4);
    apb_w(8'h08, 1);
    for (int k = 0; k < 15; k++) begin
      out_ready = (k == 12);
      @(negedge clk);
      chk($sformatf("stall_valid c%0d", k), {31'b0, out_valid},
          {31'b0, (k >= 2 && k <= 12) || k == 14});
      if (k >= 2 && k <= 12) chk($sformatf("stall_data c%0d", k), out_data, 32'hC3);
      if (k == 14) chk("stall_next_data", out_data, 32'hD4);
      step();
    end
    out_ready = 1'b0;
    rd_chk("stall_status", 8'h04, 32'h0000_2001);
    apb_w(8'h00, 32'hE5);
    apb_w(8'h00, 32'hF6);
    rd_chk("stall_status3", 8'h04, 32'h0000_2003);
    apb_w(8'h08, 3);
    @(negedge clk);
    chk("flush_valid_drop", {31'b0, out_valid}, 0);
    step();
    rd_chk("flush_status", 8'h04, 32'h0000_1A00);
    rd_chk("flush_ctrl", 8'h08, 32'h1);
    apb_w(8'h08, 0);
    apb_w(8'h04, 32'hC00);

    // ---------------- PERIOD=0 back-to-back, push on a pop cycle ----------------
    apb_w(8'h0C, 0);
    expq.delete();
    for (int i = 0; i < 8; i++) begin
      apb_w(8'h00, 32'h100 + i);
      expq.push_back(32'h100 + i);
    end
    expq.push_back(32'h77);
    out_ready = 1'b1;
    apb_w(8'h08, 1);
    idx = 0;
    for (int k = 0; k < 22; k++) begin
      if (k == 3) begin psel = 1; penable = 0; pwrite = 1; paddr = 8'h00; pwdata = 32'h77; end
      if (k == 4) penable = 1;
      if (k == 5) begin psel = 0; penable = 0; pwrite = 0; end
      @(negedge clk);
      chk($sformatf("p0_valid c%0d", k), {31'b0, out_valid},
          {31'b0, (k >= 2 && k <= 18 && (k % 2) == 0)});
      if (k == 4) chk("p0_push_pslverr", {31'b0, pslverr}, 0);
      if (out_valid && idx < expq.size()) begin
        chk($sformatf("p0_data %0d", idx), out_data, expq[idx]);
        idx++;
      end
      step();
    end
    chk("p0_delivered", idx, 9);
    apb_w(8'h08, 0);
    apb_w(8'h04, 32'hC00);
    out_ready = 1'b0;

    // ---------------- randomized against a queue model ----------------
    for (int r = 0; r < 15; r++) begin
      q.delete();
      ovf_exp = 1'b0;
      n = $urandom_range(0, 11);
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        apb(1'b1, 8'h00, w, rd, er);
        chk("rnd_pslverr", {31'b0, er}, {31'b0, q.size() >= 8});
        if (q.size() >= 8) ovf_exp = 1'b1;
        else               q.push_back(w);
      end
      rd_chk("rnd_status_fill", 8'h04,
             32'(q.size()) | (32'(q.size() == 8) << 8) | (32'(q.size() == 0) << 9) | (32'(ovf_exp) << 10));
      apb_w(8'h04, 32'h400);
      p = $urandom_range(0, 5);
      per = (p == 0) ? 1 : p;
      apb_w(8'h0C, p);
      apb_w(8'h08, 1);
      c = 0; last_tick = -1; prev_ov = 0; prev_tick = 0;
      while (c < 400 && q.size() > 0) begin
        out_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        if (tick) begin
          if (last_tick < 0) chk("rnd_first_tick", c, per - 1);
          else               chk("rnd_tick_gap", c - last_tick, per);
          last_tick = c;
        end
        if (out_valid) begin
          if (!prev_ov) chk("rnd_issue_after_tick", {31'b0, prev_tick}, 1);
          chk("rnd_data", out_data, q[0]);
          if (out_ready) void'(q.pop_front());
        end
        prev_ov = out_valid;
        prev_tick = tick;
        step();
        c++;
      end
      chk("rnd_drained", q.size(), 0);
      out_ready = 1'b0;
      repeat (per + 2) step();
      rd_chk("rnd_status_end", 8'h04, 32'h0000_1A00);
      apb_w(8'h08, 0);
      apb_w(8'h04, 32'hC00);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
